sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACC_LAT, default 2, number of WAIT cycles from the end of the sram_en_o pulse until sram_data_i is captured (matches the two-step begin/enddo SRAM controller).
REQ-002 clk_50MHz  input  1  system clock, 50 MHz; all logic on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req_i  input  1  instruction-fetch read request, level, held until if_ack_o.
REQ-005 if_addr_i  input  `ADDR_BUS (18)  fetch address, stable while if_req_i is high.
REQ-006 if_data_o  output  `DATA_BUS (16)  fetched word, valid in the if_ack_o cycle and held until the next IF grant completes.
REQ-007 if_ack_o  output  1  one-cycle completion pulse for IF.
REQ-008 mem_req_i  input  1  data-memory request, level, held until mem_ack_o.
REQ-009 mem_op_i  input  1  0 = read, 1 = write (op_rd/op_wr encoding of the SRAM controller).
REQ-010 mem_addr_i  input  `ADDR_BUS  data address.
REQ-011 mem_wdata_i  input  `DATA_BUS  write data.
REQ-012 mem_rdata_o  output  `DATA_BUS  read word, valid in the mem_ack_o cycle and held until the next MEM read completes.
REQ-013 mem_ack_o  output  1  one-cycle completion pulse for MEM.
REQ-014 stall_o  output  1  (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o), combinational, pipeline freeze.
REQ-015 sram_addr_o / sram_data_o / sram_op_o / sram_en_o  output  `ADDR_BUS / `DATA_BUS / 1 / 1  to the SRAM controller addr, data_i, op and en inputs.
REQ-016 sram_data_i  input  `DATA_BUS  from the SRAM controller data_o.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, with a 2-bit wait counter.
REQ-018 IDLE: if any request is high, latch the winner id, address, op (IF forces read) and write data, then go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: sram_en_o = 1 for exactly one cycle, counter cleared, go to WAIT.
REQ-020 WAIT: counter increments each cycle; in the cycle where counter == ACC_LAT-1, on read capture sram_data_i into the winner's data register at the edge, then go to DONE.
REQ-021 DONE: pulse the winner's ack for one cycle, go to IDLE.
REQ-022 Latency: a request sampled in IDLE at cycle 0 gives ISSUE at 1, WAIT at 2..ACC_LAT+1, and ack at ACC_LAT+2 (cycle 4 at default).
REQ-023 sram_addr_o, sram_op_o and sram_data_o SHALL hold the latched values from ISSUE through DONE and remain unchanged in IDLE.
REQ-024 Arbitration (fixed priority) happens only in IDLE: MEM beats IF; a loser keeps its request and is served next, with no preemption of a granted access.
REQ-025 Requesters SHALL drop or renew the request on the edge at which ack is seen; a request high in IDLE is always a new transaction, so back-to-back service has a 1-cycle IDLE gap.
REQ-026 Under fixed priority, continuous MEM traffic may starve IF; this is accepted behaviour.
REQ-027 If a request drops before its ack, the granted access still completes and acks; a request not yet granted is dropped silently.

Reset
REQ-028 When rst = 1 at an edge, the block SHALL go to IDLE, with sram_en_o = 0, both acks = 0, counter = 0, sram_addr_o = 0, sram_data_o = 0, sram_op_o = 0, if_data_o = 0 and mem_rdata_o = 0.
REQ-029 Reset mid-access SHALL abort with no ack; the SRAM controller shares rst and also returns to its empty state.

Configuration
REQ-030 Macro SRAM_ARB_RR_EN:
- Defined: round-robin arbitration; a last-grant register (reset value IF) gives a tie to the requester not granted last, so MEM wins the first tie after reset.
- Undefined: fixed MEM priority per REQ-024, and the last-grant register is absent.

Verification
REQ-031 Single IF read: preload SRAM 0x00010 = 0x1234; if_req_i = 1 at cycle 0 -> sram_en_o = 1 at cycle 1 only, if_ack_o = 1 at cycle 4, if_data_o = 0x1234, stall_o = 1 for cycles 0-3.
REQ-032 MEM write then read: write 0xBEEF to 0x3FFFF, then read 0x3FFFF -> mem_ack_o at cycles 4 and 9, mem_rdata_o = 0xBEEF, sram_op_o = 1 during the first access.
REQ-033 Simultaneous requests (IF 0x00020, MEM read 0x00030) at cycle 0 -> MEM ack at 4, IF ack at 9; with SRAM_ARB_RR_EN the second tie after that goes to IF first.
REQ-034 Continuous MEM requests for 20 cycles with IF pending -> no IF ack without the macro; with the macro, IF and MEM acks alternate.
REQ-035 rst = 1 at cycle 2 of an IF access -> no if_ack_o, all outputs at reset values at cycle 3, and a new request after rst falls completes in 4 cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester (IF / MEM) arbiter in front of a begin/end-style SRAM controller.
// Define SRAM_ARB_RR_EN for round-robin arbitration; the default build uses fixed MEM priority.
module sram_arbiter #(
  parameter int unsigned ACC_LAT = 2
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [17:0] if_addr_i,
  output logic [15:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_op_i,
  input  logic [17:0] mem_addr_i,
  input  logic [15:0] mem_wdata_i,
  output logic [15:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stall_o,
  output logic [17:0] sram_addr_o,
  output logic [15:0] sram_data_o,
  output logic        sram_op_o,
  output logic        sram_en_o,
  input  logic [15:0] sram_data_i
);

  localparam logic [1:0] LAST_CNT = 2'(ACC_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic        r_gnt_mem;
  logic [17:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_op;
  logic [15:0] r_if_data;
  logic [15:0] r_mem_rdata;
  logic        w_any_req;
  logic        w_pick_mem;
  logic        w_cnt_last;

  assign w_any_req  = if_req_i | mem_req_i;
  assign w_cnt_last = (r_cnt == LAST_CNT);

`ifdef SRAM_ARB_RR_EN
  // Last-grant memory: a tie goes to whoever was not served last.
  logic r_last_mem;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_last_mem <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_mem <= w_pick_mem;
    end
  end

  assign w_pick_mem = mem_req_i & (~if_req_i | ~r_last_mem);
`else
  assign w_pick_mem = mem_req_i;
`endif

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_cnt_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sram_en_o = 1'b0;
    if_ack_o  = 1'b0;
    mem_ack_o = 1'b0;
    case (r_state)
      S_ISSUE: sram_en_o = 1'b1;
      S_DONE: begin
        if_ack_o  = ~r_gnt_mem;
        mem_ack_o = r_gnt_mem;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_cnt       <= '0;
      r_gnt_mem   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op        <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_mem <= w_pick_mem;
            r_addr    <= w_pick_mem ? mem_addr_i : if_addr_i;
            r_op      <= w_pick_mem & mem_op_i;
            r_wdata   <= mem_wdata_i;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 2'd1;
          if (w_cnt_last && !r_op) begin
            if (r_gnt_mem) r_mem_rdata <= sram_data_i;
            else           r_if_data   <= sram_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign sram_addr_o = r_addr;
  assign sram_data_o = r_wdata;
  assign sram_op_o   = r_op;
  assign if_data_o   = r_if_data;
  assign mem_rdata_o = r_mem_rdata;
  assign stall_o     = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_sram_arbiter;

  localparam int ACC_LAT = 2;
  localparam int ACK_AT  = ACC_LAT + 2;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [17:0] if_addr_i = '0;
  logic [15:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i = 1'b0;
  logic        mem_op_i = 1'b0;
  logic [17:0] mem_addr_i = '0;
  logic [15:0] mem_wdata_i = '0;
  logic [15:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        stall_o;
  logic [17:0] sram_addr_o;
  logic [15:0] sram_data_o;
  logic        sram_op_o;
  logic        sram_en_o;
  logic [15:0] sram_data_i;

  sram_arbiter #(.ACC_LAT(ACC_LAT)) dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_ack_o   (if_ack_o),
    .mem_req_i  (mem_req_i),
    .mem_op_i   (mem_op_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_ack_o  (mem_ack_o),
    .stall_o    (stall_o),
    .sram_addr_o(sram_addr_o),
    .sram_data_o(sram_data_o),
    .sram_op_o  (sram_op_o),
    .sram_en_o  (sram_en_o),
    .sram_data_i(sram_data_i)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, want);
    end
  endtask

  function automatic logic [15:0] init_word(input int unsigned a);
    case (a)
      32'h10:  return 16'h1234;
      32'h20:  return 16'hA5A5;
      32'h30:  return 16'h5A5A;
      default: return 16'((a * 32'd40503) ^ (a >> 3) ^ 32'h9E37);
    endcase
  endfunction

  // SRAM device stand-in: address-indexed read, write committed on the enable edge
  logic [15:0] sram_mem [0:262143];
  assign sram_data_i = sram_mem[sram_addr_o];

  initial begin
    for (int unsigned a = 0; a < 262144; a++) sram_mem[a] = init_word(a);
    forever begin
      @(posedge clk_50MHz);
      if (sram_en_o && sram_op_o) sram_mem[sram_addr_o] = sram_data_o;
    end
  end

  // Reference model: m_k counts cycles since the grant cycle (-1 when idle)
  logic [15:0] ref_mem [0:262143];
  int          m_k = -1;
  bit          m_live = 1'b0;
  bit          m_win_mem, m_op, m_last_mem;
  logic [17:0] m_addr;
  logic [15:0] m_wdata, m_if_data, m_mem_rdata;
  bit          e_ack, e_ifa, e_mema;

  initial begin
    for (int unsigned a = 0; a < 262144; a++) ref_mem[a] = init_word(a);
    forever begin
      @(negedge clk_50MHz);
      if (m_live) begin
        e_ack  = (m_k == ACK_AT);
        e_ifa  = e_ack && !m_win_mem;
        e_mema = e_ack && m_win_mem;
        if (e_ack && !m_op) begin
          if (m_win_mem) m_mem_rdata = ref_mem[m_addr];
          else           m_if_data   = ref_mem[m_addr];
        end
        chk("sram_en", sram_en_o, m_k == 1);
        chk("if_ack", if_ack_o, e_ifa);
        chk("mem_ack", mem_ack_o, e_mema);
        chk("stall", stall_o, (if_req_i && !e_ifa) || (mem_req_i && !e_mema));
        chk("sram_addr", sram_addr_o, m_addr);
        chk("sram_op", sram_op_o, m_op);
        chk("sram_data", sram_data_o, m_wdata);
        chk("if_data", if_data_o, m_if_data);
        chk("mem_rdata", mem_rdata_o, m_mem_rdata);
      end
      if (m_k == 1 && m_op) ref_mem[m_addr] = m_wdata;
      if (rst) begin
        m_live = 1'b1; m_k = -1; m_last_mem = 1'b0; m_win_mem = 1'b0; m_op = 1'b0;
        m_addr = '0; m_wdata = '0; m_if_data = '0; m_mem_rdata = '0;
      end else if (m_live) begin
        if (m_k < 0) begin
          if (if_req_i || mem_req_i) begin
`ifdef SRAM_ARB_RR_EN
            m_win_mem = mem_req_i && (!if_req_i || !m_last_mem);
`else
            m_win_mem = mem_req_i;
`endif
            m_last_mem = m_win_mem;
            m_addr  = m_win_mem ? mem_addr_i : if_addr_i;
            m_op    = m_win_mem && mem_op_i;
            m_wdata = mem_wdata_i;
            m_k     = 1;
          end
        end else if (m_k == ACK_AT) begin
          m_k = -1;
        end else begin
          m_k++;
        end
      end
    end
  end

  task automatic next();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req_i = 1'b0; mem_req_i = 1'b0;
    next();
    rst = 1'b0;
  endtask

  task automatic t_tie(input bit renew);
    bit em, ei;
    do_reset();
    if_addr_i = 18'h20; if_req_i = 1'b1;
    mem_addr_i = 18'h30; mem_op_i = 1'b0; mem_req_i = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      if (!renew) begin
        em = (i == 4); ei = (i == 9);
      end else begin
`ifdef SRAM_ARB_RR_EN
        em = (i == 4) || (i == 14); ei = (i == 9);
`else
        em = (i == 4) || (i == 9); ei = (i == 14);
`endif
      end
      @(negedge clk_50MHz);
      chk("tie_mem_ack", mem_ack_o, em);
      chk("tie_if_ack", if_ack_o, ei);
      if (em) chk("tie_mem_data", mem_rdata_o, 16'h5A5A);
      if (ei) chk("tie_if_data", if_data_o, 16'hA5A5);
      next();
      if (em && !(renew && i == 4)) mem_req_i = 1'b0;
      if (ei) if_req_i = 1'b0;
    end
  endtask

  task automatic new_if();
    if_req_i  = 1'b1;
    if_addr_i = 18'($urandom_range(15)) | ($urandom_range(1) != 0 ? 18'h3FFF0 : 18'h0);
  endtask

  task automatic new_mem();
    mem_req_i   = 1'b1;
    mem_op_i    = 1'($urandom_range(1));
    mem_addr_i  = 18'($urandom_range(15)) | ($urandom_range(1) != 0 ? 18'h3FFF0 : 18'h0);
    mem_wdata_i = 16'($urandom);
  endtask

  initial begin
    int  if_acks;
    bit  ia, ma;
    next();
    next();
    rst = 1'b0;

    // MEM write then read-back at the top address
    do_reset();
    mem_req_i = 1'b1; mem_op_i = 1'b1; mem_addr_i = 18'h3FFFF; mem_wdata_i = 16'hBEEF;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk_50MHz);
      chk("wr_rd_ack", mem_ack_o, (i == 4) || (i == 9));
      if (i >= 1 && i <= 4) chk("wr_op", sram_op_o, 1'b1);
      if (i >= 6) chk("rd_op", sram_op_o, 1'b0);
      if (i >= 1) chk("wr_rd_addr", sram_addr_o, 18'h3FFFF);
      if (i == 9) chk("rd_data", mem_rdata_o, 16'hBEEF);
      next();
      if (i == 4) mem_op_i = 1'b0;
    end
    mem_req_i = 1'b0;

    // Single IF read
    if_addr_i = 18'h10; if_req_i = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk_50MHz);
      chk("if_en", sram_en_o, i == 1);
      chk("if_ack1", if_ack_o, i == 4);
      chk("if_stall", stall_o, i <= 3);
      if (i == 4) chk("if_data1", if_data_o, 16'h1234);
      next();
    end
    if_req_i = 1'b0;

    // Reset in the middle of an IF access
    if_addr_i = 18'h10; if_req_i = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk_50MHz);
      chk("rst_if_ack", if_ack_o, i == 7);
      if (i == 3) begin
        chk("rst_en", sram_en_o, 1'b0);
        chk("rst_mem_ack", mem_ack_o, 1'b0);
        chk("rst_addr", sram_addr_o, 18'h0);
        chk("rst_wdata", sram_data_o, 16'h0);
        chk("rst_op", sram_op_o, 1'b0);
        chk("rst_if_data", if_data_o, 16'h0);
        chk("rst_mem_rdata", mem_rdata_o, 16'h0);
      end
      if (i == 7) chk("rst_if_data2", if_data_o, 16'h1234);
      next();
      if (i == 1) rst = 1'b1;
      if (i == 2) rst = 1'b0;
    end
    if_req_i = 1'b0;

    t_tie(1'b0);
    t_tie(1'b1);

    // Continuous MEM traffic with IF pending
    do_reset();
    if_addr_i = 18'h10; if_req_i = 1'b1;
    mem_addr_i = 18'h20; mem_op_i = 1'b0; mem_req_i = 1'b1;
    if_acks = 0;
    for (int i = 0; i <= 19; i++) begin
      bit ack_slot, if_turn;
      ack_slot = (i >= 4) && ((i - 4) % 5 == 0);
`ifdef SRAM_ARB_RR_EN
      if_turn = (((i - 4) / 5) % 2) == 1;
`else
      if_turn = 1'b0;
`endif
      @(negedge clk_50MHz);
      chk("starve_mem_ack", mem_ack_o, ack_slot && !if_turn);
      chk("starve_if_ack", if_ack_o, ack_slot && if_turn);
      if (if_ack_o) if_acks++;
      next();
    end
`ifdef SRAM_ARB_RR_EN
    chk("starve_if_count", if_acks, 2);
`else
    chk("starve_if_count", if_acks, 0);
`endif
    if_req_i = 1'b0; mem_req_i = 1'b0;

    // Randomized traffic, occasional drops and resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_50MHz);
      ia = if_ack_o;
      ma = mem_ack_o;
      next();
      rst = ($urandom_range(299) == 0);
      if (if_req_i) begin
        if (ia) begin
          if ($urandom_range(1) != 0) new_if(); else if_req_i = 1'b0;
        end else if ($urandom_range(31) == 0) begin
          if_req_i = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        new_if();
      end
      if (mem_req_i) begin
        if (ma) begin
          if ($urandom_range(1) != 0) new_mem(); else mem_req_i = 1'b0;
        end else if ($urandom_range(31) == 0) begin
          mem_req_i = 1'b0;
        end
      end else if ($urandom_range(2) == 0) begin
        new_mem();
      end
    end
    rst = 1'b0; if_req_i = 1'b0; mem_req_i = 1'b0;
    repeat (8) next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
